// File: rtl/spi_slave_param.sv
// SPI slave between a serial master and the single-port RAM: it decodes {cmd, payload}
// frames into rx_data and shifts RAM read data back out on MISO.
module spi_slave_param #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         SS_n,
  input  logic         MOSI,
  input  logic         tx_valid,
  input  logic [W-1:0] tx_data,
  output logic         MISO,
  output logic         rx_valid,
  output logic [W+1:0] rx_data,
  output logic         frame_err,
  output logic         busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CHK_CMD   = 3'd1;
  localparam logic [2:0] WRITE     = 3'd2;
  localparam logic [2:0] READ_ADD  = 3'd3;
  localparam logic [2:0] READ_DATA = 3'd4;
  localparam logic [2:0] TX_WAIT   = 3'd5;
  localparam logic [2:0] TX_SHIFT  = 3'd6;

  localparam int          CW   = $clog2(W + 2);
  localparam logic [CW-1:0] LAST = CW'(W);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [2:0]    state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [W-1:0]  shift_r, shift_s, shift_in_s;
  logic [1:0]    cmd_r, cmd_s;
  logic          illegal_r, illegal_s;
  logic          done_r, done_s;
  logic          rd_pending_r, rd_pending_s;
  logic [W-1:0]  tx_sr_r, tx_sr_s;
  logic          miso_r, miso_s;
  logic          rx_valid_r, rx_valid_s;
  logic [W+1:0]  rx_data_r, rx_data_s;
  logic          frame_err_r, frame_err_s;
  logic          busy_r;

  // Head bit and remainder of a word in wire order.
  function automatic logic tx_head(input logic [W-1:0] v);
    return MSB_FIRST ? v[W-1] : v[0];
  endfunction

  function automatic logic [W-1:0] tx_next(input logic [W-1:0] v);
    return MSB_FIRST ? {v[W-2:0], 1'b0} : {1'b0, v[W-1:1]};
  endfunction

  assign shift_in_s = MSB_FIRST ? {shift_r[W-2:0], MOSI} : {MOSI, shift_r[W-1:1]};

  // Next-state and output decode; done_r marks a finished frame waiting for SS_n to rise.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    shift_s      = shift_r;
    cmd_s        = cmd_r;
    illegal_s    = illegal_r;
    done_s       = done_r;
    rd_pending_s = rd_pending_r;
    tx_sr_s      = tx_sr_r;
    miso_s       = 1'b0;
    rx_valid_s   = 1'b0;
    rx_data_s    = rx_data_r;
    frame_err_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!SS_n) begin
          state_s   = CHK_CMD;
          cnt_s     = '0;
          done_s    = 1'b0;
          illegal_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      CHK_CMD: begin
        if (SS_n) begin
          frame_err_s = 1'b1;
          state_s     = IDLE;
        end else begin
          cmd_s = {MOSI, 1'b0};
          cnt_s = '0;
          if (!MOSI) state_s = WRITE;
          else if (rd_pending_r) state_s = READ_DATA;
          else state_s = READ_ADD;
        end
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (done_r) begin
          if (SS_n) state_s = IDLE;
          else state_s = state_r;
        end else if (SS_n) begin
          frame_err_s = 1'b1;
          state_s     = IDLE;
        end else if (cnt_r == '0) begin
          cmd_s[0]  = MOSI;
          illegal_s = ((state_r == READ_ADD) && MOSI) || ((state_r == READ_DATA) && !MOSI);
          cnt_s     = cnt_r + ONE;
        end else begin
          shift_s = shift_in_s;
          cnt_s   = cnt_r + ONE;
          if (cnt_r == LAST) begin
            if (illegal_r) begin
              frame_err_s = 1'b1;
              done_s      = 1'b1;
            end else begin
              rx_valid_s = 1'b1;
              rx_data_s  = {cmd_r, shift_in_s};
              if (state_r == READ_DATA) begin
                state_s = TX_WAIT;
              end else begin
                done_s = 1'b1;
                if (state_r == READ_ADD) rd_pending_s = 1'b1;
                else rd_pending_s = rd_pending_r;
              end
            end
          end else begin
            done_s = 1'b0;
          end
        end
      end
      TX_WAIT: begin
        if (SS_n) begin
          frame_err_s = 1'b1;
          state_s     = IDLE;
        end else if (tx_valid) begin
          miso_s  = tx_head(tx_data);
          tx_sr_s = tx_next(tx_data);
          cnt_s   = ONE;
          done_s  = 1'b0;
          state_s = TX_SHIFT;
        end else begin
          state_s = TX_WAIT;
        end
      end
      TX_SHIFT: begin
        if (done_r) begin
          if (SS_n) state_s = IDLE;
          else state_s = TX_SHIFT;
        end else if (cnt_r == LAST) begin
          rd_pending_s = 1'b0;
          if (SS_n) state_s = IDLE;
          else done_s = 1'b1;
        end else if (SS_n) begin
          frame_err_s = 1'b1;
          state_s     = IDLE;
        end else begin
          miso_s  = tx_head(tx_sr_r);
          tx_sr_s = tx_next(tx_sr_r);
          cnt_s   = cnt_r + ONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      shift_r      <= '0;
      cmd_r        <= 2'b00;
      illegal_r    <= 1'b0;
      done_r       <= 1'b0;
      rd_pending_r <= 1'b0;
      tx_sr_r      <= '0;
      miso_r       <= 1'b0;
      rx_valid_r   <= 1'b0;
      rx_data_r    <= '0;
      frame_err_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      shift_r      <= shift_s;
      cmd_r        <= cmd_s;
      illegal_r    <= illegal_s;
      done_r       <= done_s;
      rd_pending_r <= rd_pending_s;
      tx_sr_r      <= tx_sr_s;
      miso_r       <= miso_s;
      rx_valid_r   <= rx_valid_s;
      rx_data_r    <= rx_data_s;
      frame_err_r  <= frame_err_s;
      busy_r       <= (state_s != IDLE);
    end
  end

  assign MISO      = miso_r;
  assign rx_valid  = rx_valid_r;
  assign rx_data   = rx_data_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;

endmodule
